// File: rtl/axil2wb_master.sv
// axil2wb_master
// AXI-Lite slave to classic Wishbone master bridge. Each AXI-Lite single read
// or write becomes exactly one Wishbone cycle at pWB_BASE | axi_addr. The data
// and response come back on R/B. A cycle the slave never acknowledges is ended
// after pTIMEOUT strobe cycles with SLVERR.
//
// Ports
//   wb_clk_i, wb_rst_i            clock, asynchronous active-high reset
//   awvalid/awready/awaddr        AXI-Lite write address channel
//   wvalid/wready/wdata/wstrb     AXI-Lite write data channel
//   bvalid/bready/bresp           AXI-Lite write response channel
//   arvalid/arready/araddr        AXI-Lite read address channel
//   rvalid/rready/rdata/rresp     AXI-Lite read data channel
//   wbm_*                         Wishbone classic master interface
module axil2wb_master #(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH = 32,
    parameter logic [31:0] pWB_BASE    = 32'h3000_0000,
    parameter int unsigned pTIMEOUT    = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [pADDR_WIDTH-1:0]   awaddr,
    input  logic                     wvalid,
    output logic                     wready,
    input  logic [pDATA_WIDTH-1:0]   wdata,
    input  logic [pDATA_WIDTH/8-1:0] wstrb,
    output logic                     bvalid,
    input  logic                     bready,
    output logic [1:0]               bresp,
    input  logic                     arvalid,
    output logic                     arready,
    input  logic [pADDR_WIDTH-1:0]   araddr,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [pDATA_WIDTH-1:0]   rdata,
    output logic [1:0]               rresp,
    output logic                     wbm_cyc_o,
    output logic                     wbm_stb_o,
    output logic                     wbm_we_o,
    output logic [pDATA_WIDTH/8-1:0] wbm_sel_o,
    output logic [31:0]              wbm_adr_o,
    output logic [pDATA_WIDTH-1:0]   wbm_dat_o,
    input  logic [pDATA_WIDTH-1:0]   wbm_dat_i,
    input  logic                     wbm_ack_i
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    // Last strobe cycle that may still be acked before error termination.
    localparam logic [7:0] TO_LAST     = 8'(pTIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WB_WR, WB_RD, B_RESP, R_RESP} state_t;

    state_t                   state, state_nxt;
    logic                     aw_hold, w_hold, ar_hold;
    logic [pADDR_WIDTH-1:0]   aw_addr_q, ar_addr_q;
    logic [pDATA_WIDTH-1:0]   w_data_q;
    logic [pDATA_WIDTH/8-1:0] w_strb_q;
    logic                     rd_first;   // read wins the next contention
    logic [7:0]               to_cnt;
    logic                     grant_wr, grant_rd, b_done, r_done;
    logic                     wb_active, timeout_hit, wb_done;

    assign awready = ~aw_hold & ~wb_rst_i;
    assign wready  = ~w_hold  & ~wb_rst_i;
    assign arready = ~ar_hold & ~wb_rst_i;

    assign wb_active   = (state == WB_WR) || (state == WB_RD);
    // An ack in the final allowed cycle takes precedence over the timeout.
    assign timeout_hit = wb_active && !wbm_ack_i && (to_cnt == TO_LAST);
    assign wb_done     = wb_active && (wbm_ack_i || timeout_hit);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        b_done    = 1'b0;
        r_done    = 1'b0;
        case (state)
            IDLE: begin
                if (aw_hold && w_hold && (!ar_hold || !rd_first)) begin
                    state_nxt = WB_WR;
                    grant_wr  = 1'b1;
                end else if (ar_hold) begin
                    state_nxt = WB_RD;
                    grant_rd  = 1'b1;
                end
            end
            WB_WR:   if (wb_done) state_nxt = B_RESP;
            WB_RD:   if (wb_done) state_nxt = R_RESP;
            B_RESP: if (bready) begin
                state_nxt = IDLE;
                b_done    = 1'b1;
            end
            R_RESP: if (rready) begin
                state_nxt = IDLE;
                r_done    = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture; a hold is only released by its own response handshake.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            aw_hold   <= 1'b0;
            w_hold    <= 1'b0;
            ar_hold   <= 1'b0;
            aw_addr_q <= '0;
            ar_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            rd_first  <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                aw_hold   <= 1'b1;
                aw_addr_q <= awaddr;
            end else if (b_done) begin
                aw_hold   <= 1'b0;
            end
            if (wvalid && wready) begin
                w_hold   <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end else if (b_done) begin
                w_hold   <= 1'b0;
            end
            if (arvalid && arready) begin
                ar_hold   <= 1'b1;
                ar_addr_q <= araddr;
            end else if (r_done) begin
                ar_hold   <= 1'b0;
            end
            if (grant_wr)      rd_first <= 1'b1;
            else if (grant_rd) rd_first <= 1'b0;
        end
    end

    // Wishbone outputs are loaded once per cycle and held until termination.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
        end else if (grant_wr) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            wbm_sel_o <= w_strb_q;
            wbm_adr_o <= pWB_BASE | 32'(aw_addr_q);
            wbm_dat_o <= w_data_q;
        end else if (grant_rd) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '1;
            wbm_adr_o <= pWB_BASE | 32'(ar_addr_q);
        end else if (wb_done) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)       to_cnt <= '0;
        else if (wb_active) to_cnt <= wb_done ? 8'd0 : to_cnt + 8'd1;
        else                to_cnt <= '0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
            rvalid <= 1'b0;
            rresp  <= RESP_OKAY;
            rdata  <= '0;
        end else begin
            if (state == WB_WR && wb_done) begin
                bvalid <= 1'b1;
                bresp  <= wbm_ack_i ? RESP_OKAY : RESP_SLVERR;
            end else if (b_done) begin
                bvalid <= 1'b0;
            end
            if (state == WB_RD && wb_done) begin
                rvalid <= 1'b1;
                rresp  <= wbm_ack_i ? RESP_OKAY : RESP_SLVERR;
                rdata  <= wbm_ack_i ? wbm_dat_i : '0;
            end else if (r_done) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/axil2wb_master.md
Name: axil2wb_master

Overview:
AXI-Lite slave to Wishbone master bridge, the reverse direction of the existing Wishbone-to-AXI bridge.
An AXI-Lite initiator, such as a test-harness or LA-driven controller, issues single reads and writes. The block turns each one into one classic Wishbone cycle toward the user-project address space (FIR bridge at 0x3000_0000).
It returns the data and response on the AXI-Lite R/B channels and terminates unanswered cycles with a timeout error.

Parameters:
pADDR_WIDTH, 12, AXI-Lite address width (byte address).
pDATA_WIDTH, 32, data width; only 32 is supported.
pWB_BASE, 32'h3000_0000, base OR-ed onto the AXI address; its low pADDR_WIDTH bits must be zero.
pTIMEOUT, 255, number of stb-high cycles without ack before error termination (1..255).

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  pADDR_WIDTH  write byte address
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  32  write data
wstrb  in  4  byte strobes
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  00 OKAY, 10 SLVERR
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  pADDR_WIDTH  read byte address
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  32  read data
rresp  out  2  00 OKAY, 10 SLVERR
wbm_cyc_o  out  1  WB cycle
wbm_stb_o  out  1  WB strobe
wbm_we_o  out  1  WB write enable
wbm_sel_o  out  4  WB byte select
wbm_adr_o  out  32  WB address
wbm_dat_o  out  32  WB write data
wbm_dat_i  in  32  WB read data
wbm_ack_i  in  1  WB acknowledge

Behaviour:
- Reset: all WB outputs 0; bvalid, rvalid, bresp, rresp, rdata 0; hold flags cleared; FSM IDLE; timeout counter 0; arbitration pointer = write-first. awready/wready/arready are 0 while wb_rst_i is high.
- Capture registers:
  - aw_hold, w_hold and ar_hold are set independently on their valid&ready handshake.
  - awready = ~aw_hold, wready = ~w_hold, arready = ~ar_hold (gated by reset).
  - AW and W may arrive in either order or in the same cycle.
- FSM states: IDLE, WB_WR, WB_RD, B_RESP, R_RESP.
  - IDLE: write pair ready = aw_hold & w_hold.
    - Only the write pair ready -> WB_WR.
    - Only ar_hold -> WB_RD.
    - Both -> the one not served last (round-robin pointer), write first after reset.
  - WB_WR / WB_RD:
    - cyc=stb=1, registered; asserted the cycle after entering from IDLE.
    - Write: we=1, adr=pWB_BASE|awaddr, sel=wstrb, dat=wdata.
    - Read: we=0, sel=4'hF.
    - Outputs stay stable until termination.
    - On ack sampled high: cyc/stb/we drop next cycle, resp=OKAY, rdata<=wbm_dat_i for reads, go to B_RESP/R_RESP.
  - Timeout:
    - Counter increments each stb-high cycle without ack.
    - Reaching pTIMEOUT drops cyc/stb, sets resp=SLVERR and rdata=0.
    - Ack in the same cycle as the timeout wins: OKAY.
  - B_RESP: bvalid=1 until bvalid&bready; then clear aw_hold and w_hold, go to IDLE.
  - R_RESP: rvalid=1 until rvalid&rready; then clear ar_hold, go to IDLE.
  - The corresponding ready rises in the cycle after the response handshake.
- Exactly one WB cycle is outstanding; cyc is never held across transactions (no block transfers).
- Backpressure:
  - bready/rready held low stalls the FSM indefinitely; response outputs remain stable.
  - The opposite-direction request may be captured meanwhile but is served only after return to IDLE.
- wbm_ack_i outside WB_WR/WB_RD is ignored.
- Zero-wait latency: handshake at edge k, cyc high from k+1, ack at k+1 sampled at edge k+2, bvalid/rvalid high from k+2 through k+3.
- Reset mid-operation: cyc/stb and valids drop asynchronously; pending captures are discarded and no response is issued.

Test Plan:
- AW 0x040 + W 0x0000_0005 strb F same cycle, ack 2 cycles after stb -> one WB write adr 0x3000_0040, we=1, sel F, dat 5; bvalid bresp 00; awready/wready return 1 after bready.
- W 0x11 issued 3 cycles before AW 0x010 -> wready drops after W handshake, no cyc until AW captured, exactly one WB write to 0x3000_0010.
- AR 0x084, slave acks with 0x1234_5678, rready low 4 cycles -> rvalid held, rdata 0x1234_5678, rresp 00, single WB read, cyc low during stall.
- pTIMEOUT=8, no ack on write to 0x3000_00F0 -> cyc/stb drop after 8 stb cycles, bresp 10; subsequent read still completes OKAY.
- Write pair and AR both pending in IDLE twice in a row -> order write, read, then read, write; ack coincident with timeout -> OKAY.
- Reset asserted while WB_RD stb high -> cyc/stb/rvalid 0 immediately; after release arready=1 and a new read completes with correct data.
